// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and default geometry for the two-port SRAM arbiter/controller.
package sram_ctrl_pkg;

  localparam int unsigned DefaultAw = 18;
  localparam int unsigned DefaultDw = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StTurn   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_arb_ctrl_if.sv
// Requester-side bus of the SRAM controller: two request ports plus shared completion/status.
interface sram_arb_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter; a lone requester always wins, ties go to the port not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Index of the most recent grant; resets to 1 so port 0 wins the first tie.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-port asynchronous SRAM controller: round-robin grant, then SETUP / ACCESS x N / TURN.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arb_ctrl_if.slave bus,
  output logic [AW-1:0]  sram_addr,
  output logic           sram_cs_n,
  output logic           sram_oe_n,
  output logic           sram_we_n,
  output logic [DW-1:0]  sram_d_o,
  output logic           sram_d_oe,
  input  logic [DW-1:0]  sram_d_i
);

  localparam int unsigned    CntW    = $clog2(ACCESS_CYC + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYC - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic            port_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      gnt;
  logic            advance;

  // Arbitration history only moves when a request is actually accepted in IDLE.
  assign advance = (state_q == StIdle);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1, bus.req0}),
    .advance (advance),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      port_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= '0;
      sram_addr <= '0;
      sram_cs_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_d_o  <= '0;
      sram_d_oe <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt != 2'b00) begin
            port_q    <= gnt[1];
            we_q      <= gnt[1] ? bus.we1 : bus.we0;
            sram_addr <= gnt[1] ? bus.addr1 : bus.addr0;
            sram_d_o  <= gnt[1] ? bus.wdata1 : bus.wdata0;
            sram_d_oe <= gnt[1] ? bus.we1 : bus.we0;
            sram_cs_n <= 1'b0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          cnt_q     <= CntLoad;
          sram_oe_n <= we_q;
          sram_we_n <= !we_q;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              rdata_q <= sram_d_i;
            end
            sram_cs_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            ack0_q    <= !port_q;
            ack1_q    <= port_q;
            state_q   <= StTurn;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StTurn: begin
          // Write data was held through TURN; release the bus on the way back to IDLE.
          sram_d_oe <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench: two controllers (ACCESS_CYC 2 and 1) on behavioural SRAMs; a negedge
// monitor pops expected acks and checks bus safety every cycle.
module tb_sram_arb_ctrl;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int AC0 = 2;
  localparam int AC1 = 1;

  typedef struct {
    int            port;
    int            cyc;
    logic [DW-1:0] rdata;
    int            wlow;
    int            olow;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [AW-1:0] sa   [2];
  logic          cs_n [2];
  logic          oe_n [2];
  logic          we_n [2];
  logic          doe  [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] din  [2];

  logic [DW-1:0] mem0    [0:(1<<AW)-1];
  logic [DW-1:0] mem1    [0:(1<<AW)-1];
  logic [DW-1:0] shadow0 [0:(1<<AW)-1];
  logic [DW-1:0] shadow1 [0:(1<<AW)-1];
  logic [DW-1:0] last_rd [2];
  int            wl [2];
  int            ol [2];
  exp_t          q0 [$];
  exp_t          q1 [$];

  sram_arb_ctrl_if #(.AW(AW), .DW(DW)) bus0 ();
  sram_arb_ctrl_if #(.AW(AW), .DW(DW)) bus1 ();

  sram_arb_ctrl #(.ACCESS_CYC(AC0), .AW(AW), .DW(DW)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0),
    .sram_addr (sa[0]),
    .sram_cs_n (cs_n[0]),
    .sram_oe_n (oe_n[0]),
    .sram_we_n (we_n[0]),
    .sram_d_o  (dout[0]),
    .sram_d_oe (doe[0]),
    .sram_d_i  (din[0])
  );

  sram_arb_ctrl #(.ACCESS_CYC(AC1), .AW(AW), .DW(DW)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .sram_addr (sa[1]),
    .sram_cs_n (cs_n[1]),
    .sram_oe_n (oe_n[1]),
    .sram_we_n (we_n[1]),
    .sram_d_o  (dout[1]),
    .sram_d_oe (doe[1]),
    .sram_d_i  (din[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous SRAMs: write on we_n low, read data valid while oe_n low.
  always @(posedge clk) begin
    if (!cs_n[0] && !we_n[0]) mem0[sa[0]] <= dout[0];
    if (!cs_n[1] && !we_n[1]) mem1[sa[1]] <= dout[1];
  end

  always @(negedge clk) begin
    din[0] <= (!cs_n[0] && !oe_n[0]) ? mem0[sa[0]] : 16'hBEEF;
    din[1] <= (!cs_n[1] && !oe_n[1]) ? mem1[sa[1]] : 16'hBEEF;
  end

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d @cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, expv);
    end
  endtask

  task automatic drive(input int d, input int port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (d == 0 && port == 0) begin
      bus0.req0 = req; bus0.we0 = we; bus0.addr0 = addr; bus0.wdata0 = wdata;
    end else if (d == 0) begin
      bus0.req1 = req; bus0.we1 = we; bus0.addr1 = addr; bus0.wdata1 = wdata;
    end else if (port == 0) begin
      bus1.req0 = req; bus1.we0 = we; bus1.addr0 = addr; bus1.wdata0 = wdata;
    end else begin
      bus1.req1 = req; bus1.we1 = we; bus1.addr1 = addr; bus1.wdata1 = wdata;
    end
  endtask

  task automatic push(input int d, input int port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int at);
    exp_t e;
    int   ac;
    ac     = (d == 0) ? AC0 : AC1;
    e.port = port;
    e.cyc  = at;
    e.wlow = we ? ac : 0;
    e.olow = we ? 0 : ac;
    if (we) begin
      if (d == 0) shadow0[addr] = wdata;
      else        shadow1[addr] = wdata;
    end else begin
      last_rd[d] = (d == 0) ? shadow0[addr] : shadow1[addr];
    end
    e.rdata = last_rd[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One transaction from an idle controller; req is dropped after 'hold' cycles.
  task automatic single(input int d, input int port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int hold);
    int ac;
    ac = (d == 0) ? AC0 : AC1;
    @(posedge clk);
    #1;
    drive(d, port, 1'b1, we, addr, wdata);
    push(d, port, we, addr, wdata, cyc + ac + 2);
    repeat (hold) @(posedge clk);
    #1 drive(d, port, 1'b0, we, addr, wdata);
    repeat (ac + 2 - hold) @(posedge clk);
  endtask

  task automatic mon(input int d, input logic a0, input logic a1, input logic [DW-1:0] rd,
                     input logic busy);
    exp_t e;
    chk("oe_n_low_with_d_oe", d, 32'(!oe_n[d] && doe[d]), 32'd0);
    if (a0 || a1 || !busy) chk("cs_n_in_idle_turn", d, 32'(cs_n[d]), 32'd1);
    if (!rst_n) begin
      wl[d] = 0;
      ol[d] = 0;
    end else begin
      if (!we_n[d]) wl[d]++;
      if (!oe_n[d]) ol[d]++;
      if (a0 || a1) begin
        chk("one_ack_at_a_time", d, 32'({a1, a0}), (a1 ? 32'd2 : 32'd1));
        chk("ack_expected", d, 32'((d == 0) ? q0.size() : q1.size()) != 0 ? 32'd1 : 32'd0,
            32'd1);
        if ((d == 0 && q0.size() != 0) || (d == 1 && q1.size() != 0)) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("ack_port", d, 32'(a1), 32'(e.port));
          chk("ack_cycle", d, 32'(cyc), 32'(e.cyc));
          chk("rdata", d, 32'(rd), 32'(e.rdata));
          chk("we_n_low_cycles", d, 32'(wl[d]), 32'(e.wlow));
          chk("oe_n_low_cycles", d, 32'(ol[d]), 32'(e.olow));
        end
        wl[d] = 0;
        ol[d] = 0;
      end
    end
  endtask

  initial begin
    wl[0] = 0; wl[1] = 0; ol[0] = 0; ol[1] = 0;
    forever begin
      @(negedge clk);
      mon(0, bus0.ack0, bus0.ack1, bus0.rdata, bus0.busy);
      mon(1, bus1.ack0, bus1.ack1, bus1.rdata, bus1.busy);
    end
  end

  initial begin
    int            t;
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 1'b0, 1'b0, '0, '0);
      drive(d, 1, 1'b0, 1'b0, '0, '0);
    end

    // Reset values must appear as soon as rst_n falls.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", 0, 32'(cs_n[0]), 32'd1);
    chk("rst_oe_n", 0, 32'(oe_n[0]), 32'd1);
    chk("rst_we_n", 0, 32'(we_n[0]), 32'd1);
    chk("rst_d_oe", 0, 32'(doe[0]), 32'd0);
    chk("rst_ack", 0, 32'({bus0.ack1, bus0.ack0}), 32'd0);
    chk("rst_busy", 0, 32'(bus0.busy), 32'd0);
    chk("rst_rdata", 0, 32'(bus0.rdata), 32'd0);
    chk("rst_sram_addr", 0, 32'(sa[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both ports held high: port 0 first after reset, then strict alternation.
    @(posedge clk);
    #1;
    drive(0, 0, 1'b1, 1'b1, 18'h00100, 16'h1111);
    drive(0, 1, 1'b1, 1'b0, 18'h00100, 16'h0000);
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      push(0, k % 2, (k % 2 == 0), 18'h00100, 16'h1111, t + k * (AC0 + 3) + AC0 + 2);
    end
    repeat (3 * (AC0 + 3) + AC0 + 2) @(posedge clk);
    #1;
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);

    // Write then read back on each port, then a read whose req drops in SETUP.
    single(0, 0, 1'b1, 18'h12345, 16'hA5C3, AC0 + 2);
    single(0, 0, 1'b0, 18'h12345, 16'h0000, AC0 + 2);
    single(0, 1, 1'b1, 18'h00007, 16'h5A5A, AC0 + 2);
    single(0, 1, 1'b0, 18'h00007, 16'h0000, AC0 + 2);
    single(0, 0, 1'b0, 18'h00100, 16'h0000, 1);

    // Single-cycle access controller: latency 3, including a req dropped in SETUP.
    single(1, 1, 1'b1, 18'h3FFFF, 16'hC0DE, AC1 + 2);
    single(1, 0, 1'b0, 18'h3FFFF, 16'h0000, AC1 + 2);
    single(1, 0, 1'b1, 18'h00002, 16'h0F0F, AC1 + 2);
    single(1, 1, 1'b0, 18'h00002, 16'h0000, 1);

    // Random read/write mix over a small address pool, primed so every read is known.
    for (int i = 0; i < 8; i++) begin
      single(0, i % 2, 1'b1, 18'h2AB00 + 18'(i), 16'h1000 + 16'(i), AC0 + 2);
    end
    for (int n = 0; n < 1000; n++) begin
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = 18'h2AB00 + 18'($urandom_range(0, 7));
      data = 16'($urandom);
      single(0, port, we, addr, data, AC0 + 2);
    end

    // Reset in the 2nd ACCESS cycle of a write: no ack, then port 1 served normally.
    @(posedge clk);
    #1 drive(0, 0, 1'b1, 1'b1, 18'h00055, 16'h7777);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 0, 32'(cs_n[0]), 32'd1);
    chk("abort_oe_n", 0, 32'(oe_n[0]), 32'd1);
    chk("abort_we_n", 0, 32'(we_n[0]), 32'd1);
    chk("abort_d_oe", 0, 32'(doe[0]), 32'd0);
    chk("abort_ack", 0, 32'({bus0.ack1, bus0.ack0}), 32'd0);
    chk("abort_busy", 0, 32'(bus0.busy), 32'd0);
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    single(0, 1, 1'b1, 18'h00300, 16'h3C3C, AC0 + 2);
    single(0, 1, 1'b0, 18'h12345, 16'h0000, AC0 + 2);

    repeat (6) @(posedge clk);
    #1;
    chk("acks_outstanding", 0, 32'(q0.size()), 32'd0);
    chk("acks_outstanding", 1, 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 Parameter ACCESS_CYC, default 2, number of clk cycles the strobe (oe_n or we_n) is held low; legal range 1..15.
REQ-002 Parameter AW, default 18, SRAM address width.
REQ-003 Parameter DW, default 16, SRAM data width.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req0 / req1  in  1  request from port 0 / port 1; held high until matching ack.
REQ-007 we0 / we1  in  1  1 = write, 0 = read; stable while req high.
REQ-008 addr0 / addr1  in  AW  word address; stable while req high.
REQ-009 wdata0 / wdata1  in  DW  write data; stable while req high.
REQ-010 ack0 / ack1  out  1  one-cycle completion pulse for the port.
REQ-011 rdata  out  DW  registered read data; valid in the ack cycle and held until the next read completes.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 sram_addr  out  AW  registered address to the device.
REQ-014 sram_cs_n / sram_oe_n / sram_we_n  out  1  registered active-low device strobes.
REQ-015 sram_d_o  out  DW  data driven onto the bus; sram_d_oe  out  1  tristate enable; sram_d_i  in  DW  bus sample. Tristate buffers live in the top level.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, ACCESS and TURN.
REQ-017 IDLE: if any req is high, latch the winning port, its addr, we and wdata, then go to SETUP; otherwise stay in IDLE with cs_n=oe_n=we_n=1 and d_oe=0.
REQ-018 SETUP lasts 1 cycle: cs_n=0, address driven, strobes high; for a write, d_oe=1 with d_o=wdata.
REQ-019 ACCESS lasts exactly ACCESS_CYC cycles: a read drives oe_n=0; a write drives we_n=0 with d_oe=1.
REQ-020 For a read, rdata SHALL capture sram_d_i on the clock edge that ends the last ACCESS cycle.
REQ-021 TURN lasts 1 cycle: cs_n=oe_n=we_n=1; d_oe stays 1 for a write (data hold) and is 0 for a read; the granted port's ack is 1; next state is IDLE.
REQ-022 Latency from req sampled in IDLE to ack is ACCESS_CYC+2 cycles, so the minimum period per transaction is ACCESS_CYC+3 cycles.
REQ-023 Arbitration SHALL be round-robin: with both requests high, grant the port not granted last; a single requester always wins; after reset, port 0 has priority.
REQ-024 oe_n=0 and d_oe=1 SHALL never be asserted in the same cycle.
REQ-025 A req dropped before its ack SHALL NOT abort the transaction: the transaction completes and the ack is still issued.
REQ-026 Requests arriving in non-IDLE states SHALL be ignored until the FSM returns to IDLE.
REQ-027 The ACCESS cycle counter SHALL be $clog2(ACCESS_CYC+1) bits wide and SHALL reload on every entry to ACCESS.

Reset
REQ-028 While rst_n=0, outputs SHALL immediately take these values: state IDLE, cs_n/oe_n/we_n=1, d_oe=0, ack0/ack1=0, busy=0, rdata=0, sram_addr=0, priority to port 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction with no ack; the first request after release SHALL follow REQ-017.

Structure
REQ-030 Package sram_ctrl_pkg SHALL hold the state encoding and the default AW/DW constants.
REQ-031 Two-port round-robin selection SHALL be a sub-module rr_arb2 (inputs req[1:0], a last-grant register, and an advance strobe; output a one-hot grant).

Verification
REQ-032 Write then read, single port: ACCESS_CYC=2, port 0 writes 0xA5C3 at 0x12345, then reads 0x12345 from a behavioural SRAM model -> ack0 4 cycles after each req, rdata=0xA5C3, we_n low exactly 2 cycles.
REQ-033 Simultaneous requests: req0 and req1 held high continuously -> ack order 0,1,0,1; no ack pulse longer than 1 cycle.
REQ-034 Bus safety: randomised read/write mix over 1000 transactions -> a checker never sees oe_n=0 with d_oe=1, and cs_n=1 in every TURN and IDLE cycle.
REQ-035 Reset in ACCESS: rst_n pulled low in the 2nd ACCESS cycle of a write -> strobes go high and d_oe goes low asynchronously, no ack; after release, req1 is served with ack1 at the expected latency.
REQ-036 Dropped request: req0 deasserted in SETUP -> ack0 still pulses in TURN; ACCESS_CYC=1 read -> latency 3 cycles.
